// File: rtl/spi_slave.sv
// Mode-0 SPI responder: oversamples SCK/MOSI/CS on clk, assembles received bytes
// and shifts a buffered response byte out on MISO, MSB first.
module spi_slave #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  DEFAULT_TX  = 8'hFF
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       sck_i,
    input  logic       mosi_i,
    input  logic       cs_i,
    output logic       miso_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_load_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       frame_active_o,
    output logic       tx_underrun_o
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sckSync_q, mosiSync_q, csSync_q, flush_q;
    logic                   sckS, mosiS, csS;

    logic       sckPrev_q, csPrev_q;
    logic       sckRise_q, sckFall_q, csFall_q, csRise_q;
    logic       armed_q;
    state_t     state_q;
    logic [2:0] bitCnt_q;
    logic [7:0] rxShift_q, txShift_q, rxData_q, txBuf_q;
    logic       txFull_q, rxValid_q, txUnderrun_q, miso_q;
    logic       reload_d;
    logic [7:0] reloadByte_d;

    // flush_q marks when the cs chain holds real pin samples rather than reset values
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sckSync_q  <= '0;
            mosiSync_q <= '0;
            csSync_q   <= '1;
            flush_q    <= '0;
        end else begin
            sckSync_q  <= {sckSync_q[SYNC_STAGES-2:0], sck_i};
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi_i};
            csSync_q   <= {csSync_q[SYNC_STAGES-2:0], cs_i};
            flush_q    <= {flush_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sckS  = sckSync_q[SYNC_STAGES-1];
    assign mosiS = mosiSync_q[SYNC_STAGES-1];
    assign csS   = csSync_q[SYNC_STAGES-1];

    always_comb begin
        reload_d     = ((state_q == IDLE) && csFall_q) ||
                       ((state_q == ACTIVE) && !csRise_q && sckFall_q && (bitCnt_q == 3'd0));
        reloadByte_d = txFull_q ? txBuf_q : DEFAULT_TX;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sckPrev_q    <= 1'b0;
            csPrev_q     <= 1'b1;
            sckRise_q    <= 1'b0;
            sckFall_q    <= 1'b0;
            csFall_q     <= 1'b0;
            csRise_q     <= 1'b0;
            armed_q      <= 1'b0;
            state_q      <= IDLE;
            bitCnt_q     <= 3'd0;
            rxShift_q    <= 8'h00;
            txShift_q    <= 8'h00;
            rxData_q     <= 8'h00;
            txBuf_q      <= 8'h00;
            txFull_q     <= 1'b0;
            rxValid_q    <= 1'b0;
            txUnderrun_q <= 1'b0;
            miso_q       <= 1'b1;
        end else begin
            sckPrev_q <= sckS;
            csPrev_q  <= csS;
            sckRise_q <= sckS & ~sckPrev_q;
            sckFall_q <= ~sckS & sckPrev_q;
            csRise_q  <= csS & ~csPrev_q;
            // a frame may only start after cs has really been seen high since reset
            csFall_q  <= ~csS & csPrev_q & armed_q;
            armed_q   <= armed_q | (flush_q[SYNC_STAGES-1] & csS);

            rxValid_q    <= 1'b0;
            txUnderrun_q <= reload_d & ~txFull_q;

            if (reload_d && txFull_q) begin
                txFull_q <= 1'b0;
            end else if (tx_load_i && !txFull_q) begin
                txBuf_q  <= tx_data_i;
                txFull_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    miso_q <= 1'b1;
                    if (csFall_q) begin
                        state_q   <= ACTIVE;
                        bitCnt_q  <= 3'd0;
                        txShift_q <= reloadByte_d;
                        miso_q    <= reloadByte_d[7];
                    end
                end
                ACTIVE: begin
                    if (csRise_q) begin
                        state_q  <= IDLE;
                        bitCnt_q <= 3'd0;
                        miso_q   <= 1'b1;
                    end else if (sckRise_q) begin
                        rxShift_q <= {rxShift_q[6:0], mosiS};
                        bitCnt_q  <= bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            rxData_q  <= {rxShift_q[6:0], mosiS};
                            rxValid_q <= 1'b1;
                        end
                    end else if (sckFall_q) begin
                        if (bitCnt_q != 3'd0) begin
                            txShift_q <= {txShift_q[6:0], 1'b0};
                            miso_q    <= txShift_q[6];
                        end else begin
                            txShift_q <= reloadByte_d;
                            miso_q    <= reloadByte_d[7];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miso_o         = miso_q;
    assign tx_ready_o     = ~txFull_q;
    assign rx_data_o      = rxData_q;
    assign rx_valid_o     = rxValid_q;
    assign frame_active_o = (state_q == ACTIVE);
    assign tx_underrun_o  = txUnderrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: acts as a mode-0 SPI master and checks responses.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic       cs = 1'b1;
    logic       miso;
    logic [7:0] txData = 8'h00;
    logic       txLoad = 1'b0;
    logic       txReady;
    logic [7:0] rxData;
    logic       rxValid;
    logic       frameActive;
    logic       txUnderrun;

    int testsRun = 0;
    int failures = 0;
    int rxCount = 0;
    int urCount = 0;
    logic [7:0] rxLast = 8'h00;

    spi_slave #(.SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (
        .clk_i(clk), .reset_i(reset), .sck_i(sck), .mosi_i(mosi), .cs_i(cs),
        .miso_o(miso), .tx_data_i(txData), .tx_load_i(txLoad), .tx_ready_o(txReady),
        .rx_data_o(rxData), .rx_valid_o(rxValid), .frame_active_o(frameActive),
        .tx_underrun_o(txUnderrun)
    );

    always #5 clk = ~clk;

    // Counting high cycles also catches pulses that last longer than one cycle
    always @(negedge clk) begin
        if (rxValid) begin
            rxCount++;
            rxLast = rxData;
        end
        if (txUnderrun) urCount++;
    end

    task automatic waitClks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic loadTx(input logic [7:0] d);
        txData = d;
        txLoad = 1'b1;
        @(negedge clk);
        txLoad = 1'b0;
    endtask

    // Shifts nbits MSB first; optionally loads ld during the high phase of the 8th bit
    task automatic spiXfer(input logic [7:0] mo, input int nbits, input logic doLoad,
                           input logic [7:0] ld, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = mo[i];
            waitClks(8);
            mi[i] = miso;
            sck = 1'b1;
            if (doLoad && i == 0) begin
                waitClks(5);
                loadTx(ld);
                waitClks(2);
            end else begin
                waitClks(8);
            end
            sck = 1'b0;
        end
        waitClks(8);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        waitClks(4);
        reset = 1'b0;
        waitClks(6);
        testsRun++; if (miso !== 1'b1) begin failures++; $display("[TB] FAIL reset_miso: got %b, expected 1", miso); end
        testsRun++; if (rxData !== 8'h00) begin failures++; $display("[TB] FAIL reset_rx_data: got %h, expected 00", rxData); end
        testsRun++; if (rxValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_valid: got %b, expected 0", rxValid); end
        testsRun++; if (txReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx_ready: got %b, expected 1", txReady); end
        testsRun++; if (txUnderrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_underrun: got %b, expected 0", txUnderrun); end
        testsRun++; if (frameActive !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_active: got %b, expected 0", frameActive); end
    endtask

    task automatic test_single_byte;
        logic [7:0] mi;
        int rx0;
        rx0 = rxCount;
        loadTx(8'hA5);
        testsRun++; if (txReady !== 1'b0) begin failures++; $display("[TB] FAIL single_tx_ready_full: got %b, expected 0", txReady); end
        cs = 1'b0;
        waitClks(8);
        testsRun++; if (frameActive !== 1'b1) begin failures++; $display("[TB] FAIL single_frame_active: got %b, expected 1", frameActive); end
        testsRun++; if (txReady !== 1'b1) begin failures++; $display("[TB] FAIL single_tx_ready_consumed: got %b, expected 1", txReady); end
        spiXfer(8'h3C, 8, 1'b0, 8'h00, mi);
        cs = 1'b1;
        waitClks(8);
        testsRun++; if (mi !== 8'hA5) begin failures++; $display("[TB] FAIL single_miso: got %h, expected a5", mi); end
        testsRun++; if (rxData !== 8'h3C) begin failures++; $display("[TB] FAIL single_rx_data: got %h, expected 3c", rxData); end
        testsRun++; if (rxCount - rx0 !== 1) begin failures++; $display("[TB] FAIL single_rx_pulses: got %0d, expected 1", rxCount - rx0); end
        testsRun++; if (miso !== 1'b1) begin failures++; $display("[TB] FAIL single_idle_miso: got %b, expected 1", miso); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] m0, m1, m2;
        int rx0, ur0;
        rx0 = rxCount;
        ur0 = urCount;
        loadTx(8'hF0);
        cs = 1'b0;
        waitClks(8);
        spiXfer(8'h01, 8, 1'b1, 8'h10, m0);
        testsRun++; if (rxLast !== 8'h01) begin failures++; $display("[TB] FAIL b2b_rx0: got %h, expected 01", rxLast); end
        spiXfer(8'h02, 8, 1'b1, 8'h20, m1);
        testsRun++; if (rxLast !== 8'h02) begin failures++; $display("[TB] FAIL b2b_rx1: got %h, expected 02", rxLast); end
        spiXfer(8'h03, 8, 1'b1, 8'h30, m2);
        cs = 1'b1;
        waitClks(8);
        testsRun++; if (m0 !== 8'hF0) begin failures++; $display("[TB] FAIL b2b_miso0: got %h, expected f0", m0); end
        testsRun++; if (m1 !== 8'h10) begin failures++; $display("[TB] FAIL b2b_miso1: got %h, expected 10", m1); end
        testsRun++; if (m2 !== 8'h20) begin failures++; $display("[TB] FAIL b2b_miso2: got %h, expected 20", m2); end
        testsRun++; if (rxData !== 8'h03) begin failures++; $display("[TB] FAIL b2b_rx2: got %h, expected 03", rxData); end
        testsRun++; if (rxCount - rx0 !== 3) begin failures++; $display("[TB] FAIL b2b_rx_pulses: got %0d, expected 3", rxCount - rx0); end
        testsRun++; if (urCount - ur0 !== 0) begin failures++; $display("[TB] FAIL b2b_underrun: got %0d, expected 0", urCount - ur0); end
        testsRun++; if (txReady !== 1'b1) begin failures++; $display("[TB] FAIL b2b_tx_ready: got %b, expected 1", txReady); end
    endtask

    task automatic test_underrun;
        logic [7:0] mi;
        int ur0;
        ur0 = urCount;
        cs = 1'b0;
        waitClks(8);
        testsRun++; if (urCount - ur0 !== 1) begin failures++; $display("[TB] FAIL underrun_at_cs_fall: got %0d, expected 1", urCount - ur0); end
        spiXfer(8'h55, 8, 1'b0, 8'h00, mi);
        testsRun++; if (mi !== 8'hFF) begin failures++; $display("[TB] FAIL underrun_miso: got %h, expected ff", mi); end
        testsRun++; if (urCount - ur0 !== 2) begin failures++; $display("[TB] FAIL underrun_boundary: got %0d, expected 2", urCount - ur0); end
        cs = 1'b1;
        waitClks(8);
    endtask

    task automatic test_abort;
        logic [7:0] mi;
        logic [7:0] rxBefore;
        int rx0;
        rx0 = rxCount;
        rxBefore = rxData;
        cs = 1'b0;
        waitClks(8);
        spiXfer(8'hF8, 5, 1'b0, 8'h00, mi);
        cs = 1'b1;
        waitClks(8);
        testsRun++; if (rxCount - rx0 !== 0) begin failures++; $display("[TB] FAIL abort_no_rx_valid: got %0d, expected 0", rxCount - rx0); end
        testsRun++; if (rxData !== rxBefore) begin failures++; $display("[TB] FAIL abort_rx_held: got %h, expected %h", rxData, rxBefore); end
        testsRun++; if (frameActive !== 1'b0) begin failures++; $display("[TB] FAIL abort_frame_inactive: got %b, expected 0", frameActive); end
        cs = 1'b0;
        waitClks(8);
        spiXfer(8'h81, 8, 1'b0, 8'h00, mi);
        cs = 1'b1;
        waitClks(8);
        testsRun++; if (rxData !== 8'h81) begin failures++; $display("[TB] FAIL abort_next_rx: got %h, expected 81", rxData); end
        testsRun++; if (rxCount - rx0 !== 1) begin failures++; $display("[TB] FAIL abort_next_pulses: got %0d, expected 1", rxCount - rx0); end
    endtask

    task automatic test_load_contention;
        logic [7:0] mi;
        loadTx(8'h11);
        loadTx(8'h22);
        testsRun++; if (txReady !== 1'b0) begin failures++; $display("[TB] FAIL contention_tx_ready: got %b, expected 0", txReady); end
        cs = 1'b0;
        waitClks(8);
        spiXfer(8'h7E, 8, 1'b0, 8'h00, mi);
        cs = 1'b1;
        waitClks(8);
        testsRun++; if (mi !== 8'h11) begin failures++; $display("[TB] FAIL contention_miso: got %h, expected 11", mi); end
        testsRun++; if (txReady !== 1'b1) begin failures++; $display("[TB] FAIL contention_buffer_empty: got %b, expected 1", txReady); end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] mi;
        loadTx(8'h5A);
        cs = 1'b0;
        waitClks(8);
        spiXfer(8'hA0, 4, 1'b0, 8'h00, mi);
        reset = 1'b1;
        waitClks(3);
        testsRun++; if (miso !== 1'b1) begin failures++; $display("[TB] FAIL midreset_miso: got %b, expected 1", miso); end
        testsRun++; if (rxData !== 8'h00) begin failures++; $display("[TB] FAIL midreset_rx_data: got %h, expected 00", rxData); end
        testsRun++; if (txReady !== 1'b1) begin failures++; $display("[TB] FAIL midreset_tx_ready: got %b, expected 1", txReady); end
        testsRun++; if (frameActive !== 1'b0) begin failures++; $display("[TB] FAIL midreset_frame_active: got %b, expected 0", frameActive); end
        testsRun++; if (rxValid !== 1'b0 || txUnderrun !== 1'b0) begin failures++; $display("[TB] FAIL midreset_pulses: got %b%b, expected 00", rxValid, txUnderrun); end
        reset = 1'b0;
        waitClks(10);
        testsRun++; if (frameActive !== 1'b0) begin failures++; $display("[TB] FAIL midreset_no_resume: got %b, expected 0", frameActive); end
        cs = 1'b1;
        waitClks(8);
        cs = 1'b0;
        waitClks(8);
        spiXfer(8'hC3, 8, 1'b0, 8'h00, mi);
        cs = 1'b1;
        waitClks(8);
        testsRun++; if (rxData !== 8'hC3) begin failures++; $display("[TB] FAIL midreset_fresh_rx: got %h, expected c3", rxData); end
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_back_to_back;
        test_underrun;
        test_abort;
        test_load_contention;
        test_reset_midframe;
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
